country_car_detector: RTL and testbench
=======================================

# country_car_detector

Vehicle-detection front end for the highway/country traffic controller. Synchronises and debounces the raw country-road loop sensor and counts queued vehicles. Drives the controller's `caroncountry` request, and watches the controller's country signal `csig` to retire vehicles as they leave on green. It sits between the loop-sensor pad and `signal_control`, forming the opposite end of the `caroncountry`/`csig` interface.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before the filtered loop level changes (≥2).
- `COUNT_W`, default 4: width of the vehicle queue counter.
- `clk`  in  1: single clock, rising edge.
- `clr_n`  in  1: reset, asynchronous, active-low.
- `loop_raw`  in  1: raw loop sensor, asynchronous to `clk`, high = vehicle over loop.
- `csig`  in  2: country signal from the controller, synchronous to `clk`; RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `caroncountry`  out  1: registered request to the controller, high while queue is non-zero.
- `queue_count`  out  COUNT_W: registered number of waiting vehicles.
- `overflow`  out  1: sticky flag; an arrival occurred while the counter was saturated.

## Operation
- Input path: 2-flop synchroniser on `loop_raw` → `s2`.
- Debounce counter:
  - Clears whenever `s2` equals the filtered level `filt`.
  - Increments while they differ.
  - When the counter would reach `DEBOUNCE_CYCLES`, `filt` takes `s2` and the counter clears.
- Edge detect on `filt`: rise = arrival, fall = departure. Both are single-cycle pulses, and they are mutually exclusive.
- Arrivals:
  - Increment `queue_count` in every state.
  - At `2^COUNT_W-1` the count holds and `overflow` sets. `overflow` clears only by reset.
- Departures:
  - Decrement `queue_count` only in SERVE, saturating at 0.
  - Ignored in IDLE/REQUEST, because a car stopped at the stop line stays over the loop.
- FSM:
  - IDLE: count 0. Go to REQUEST on an arrival while `csig`≠GREEN; go to SERVE on an arrival while `csig`==GREEN.
  - REQUEST: count >0, waiting. Go to SERVE when `csig`==GREEN.
  - SERVE: country green. When `csig`≠GREEN, go to REQUEST if the next count >0, else to IDLE. Remain in SERVE while GREEN, even at count 0.
- `caroncountry` is registered as (next `queue_count` != 0). It never depends combinationally on `csig`.
- YELLOW counts as not-GREEN. The encoding 2'd3 is treated as not-GREEN.

## Timing
- Reset values: `caroncountry`=0, `queue_count`=0, `overflow`=0, synchroniser=0, `filt`=0, debounce counter=0, state IDLE.
- Reset asserts asynchronously mid-operation and clears all state immediately. Outputs go low without waiting for a clock edge.
- Arrival latency: if `loop_raw` rises before edge k and stays high, then:
  - `filt` rises at edge k+1+`DEBOUNCE_CYCLES`.
  - `queue_count`/`caroncountry` update at edge k+2+`DEBOUNCE_CYCLES`. This is 7 edges at the default.
- Departure latency is identical, measured from the `loop_raw` fall.
- Pulses shorter than `DEBOUNCE_CYCLES` synchronised samples produce no count change.
- A `csig` change takes effect at the next edge. A departure in the same cycle `csig` becomes GREEN already decrements.

## Structure
- Package `traffic_pkg`: signal encodings RED/YELLOW/GREEN (2-bit) and the detector state enum IDLE/REQUEST/SERVE. `signal_control` shares the encodings.
- Sub-module `sensor_debounce`: synchroniser, debounce counter and edge pulses. Parameter `DEBOUNCE_CYCLES`; outputs `filt`, `rise`, `fall`.
- Top level holds the FSM, the saturating counter and the output registers.

## Test plan
- Reset: drive 3 arrivals with `csig`=RED, then pull `clr_n` low between edges → `caroncountry`, `queue_count`, `overflow` go 0 immediately. After release, state is IDLE.
- Debounce: `loop_raw` high 3 cycles → no change. High 8 cycles → `queue_count`=1, with `caroncountry` rising exactly 7 edges after the rise.
- Queue while red: 3 separate 8-cycle pulses with `csig`=RED → `queue_count`=3, `caroncountry`=1. The falls are ignored.
- Service: continuing from the previous scenario, set `csig`=GREEN and drive 3 departures → count 2, 1, 0. `caroncountry` drops on the edge the count reaches 0. With `csig`=RED afterwards → IDLE.
- Mixed: 2 arrivals during GREEN with 0 departures, then `csig`→YELLOW → REQUEST. `queue_count`=2, `caroncountry` stays 1.
- Saturation: 16 arrivals with `COUNT_W`=4, `csig`=RED → `queue_count`=15, `overflow`=1. `overflow` stays 1 through later service, until reset.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-controller encodings and detector state type.
// Used by country_car_detector and signal_control.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVE   = 2'd2
    } det_state_t;

    function automatic logic is_green(input logic [1:0] s);
        return s == GREEN;
    endfunction

endpackage

// File: rtl/country_car_detector_if.sv
// Detector <-> controller link: csig in, request/queue status out.
// master = controller side, slave = detector side.
interface country_car_detector_if #(
    parameter int COUNT_W = 4
);

    logic [1:0]         csig;
    logic               caroncountry;
    logic [COUNT_W-1:0] queue_count;
    logic               overflow;

    modport master (
        output csig,
        input  caroncountry,
        input  queue_count,
        input  overflow
    );

    modport slave (
        input  csig,
        output caroncountry,
        output queue_count,
        output overflow
    );

endinterface

// File: rtl/country_car_detector_sensor_debounce.sv
// Loop sensor front end: 2-flop synchroniser, debounce filter
// and single-cycle rise/fall pulses on the filtered level.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic loop_raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            filt <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= loop_raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // level has held long enough: commit and pulse
                filt <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/country_car_detector.sv
// Country-road vehicle detector: debounced loop sensor feeding a
// saturating queue counter and the IDLE/REQUEST/SERVE tracker.
module country_car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   loop_raw,
    country_car_detector_if.slave  bus
);

    localparam logic [COUNT_W-1:0] CMAX = '1;

    logic filt;
    logic rise;
    logic fall;

    det_state_t         state;
    det_state_t         state_nx;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nx;
    logic               ovf;
    logic               ovf_nx;
    logic               car;
    logic               green;
    logic               arrive;
    logic               depart;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .clr_n    (clr_n),
        .loop_raw (loop_raw),
        .filt     (filt),
        .rise     (rise),
        .fall     (fall)
    );

    assign green  = is_green(bus.csig);
    assign arrive = rise & filt;
    assign depart = fall & ~filt;

    always_comb begin
        state_nx = state;
        count_nx = count;
        ovf_nx   = ovf;
        if (arrive) begin
            if (count == CMAX) begin
                ovf_nx = 1'b1;
            end else begin
                count_nx = count + 1'b1;
            end
        end else if (depart && (state == SERVE || green)
                     && count != '0) begin
            // green arriving this cycle already serves the leaver
            count_nx = count - 1'b1;
        end
        case (state)
            IDLE: begin
                if (arrive) begin
                    state_nx = green ? SERVE : REQUEST;
                end
            end
            REQUEST: begin
                if (green) begin
                    state_nx = SERVE;
                end
            end
            SERVE: begin
                if (!green) begin
                    state_nx = (count_nx != '0) ? REQUEST : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
            car   <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            ovf   <= ovf_nx;
            car   <= (count_nx != '0);
        end
    end

    assign bus.caroncountry = car;
    assign bus.queue_count  = count;
    assign bus.overflow     = ovf;

endmodule

// File: tb/tb_country_car_detector.sv
// Directed bench for country_car_detector: vector table plus
// hand-written latency, service-to-zero, saturation and reset cases.
module tb_country_car_detector;
    import traffic_pkg::*;

    typedef struct {
        logic       rst;
        logic       loop;
        logic [1:0] csig;
        int         n;
        int         cnt;
        logic       car;
        logic       ovf;
        int         st;
    } vec_t;

    logic clk;
    logic clr_n;
    logic loop_raw;
    int   errors;
    int   checks;
    vec_t tbl[$];

    country_car_detector_if #(.COUNT_W(4)) bif ();

    country_car_detector #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_W(4)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .loop_raw (loop_raw),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sync_reset();
        loop_raw = 1'b0;
        bif.csig = RED;
        clr_n    = 1'b0;
        tick(1);
        clr_n = 1'b1;
        tick(1);
    endtask

    task automatic outs(input string tag, input int cnt,
                        input int car, input int ovf);
        check({tag, ".count"}, int'(bif.queue_count), cnt);
        check({tag, ".car"}, int'(bif.caroncountry), car);
        check({tag, ".ovf"}, int'(bif.overflow), ovf);
    endtask

    task automatic add(input logic r, input logic l, input logic [1:0] c,
                       input int n, input int cnt, input logic car,
                       input logic ovf, input int st);
        vec_t v;
        v.rst = r; v.loop = l; v.csig = c; v.n = n;
        v.cnt = cnt; v.car = car; v.ovf = ovf; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        clr_n    = 1'b0;
        loop_raw = 1'b0;
        bif.csig = RED;

        // short pulse, then filtered out
        add(1, 1, RED,    3,  0, 0, 0, IDLE);
        add(0, 0, RED,    10, 0, 0, 0, IDLE);
        // queue while red, falls ignored
        add(1, 1, RED,    8,  1, 1, 0, REQUEST);
        add(0, 0, RED,    8,  1, 1, 0, REQUEST);
        add(0, 1, RED,    8,  2, 1, 0, REQUEST);
        add(0, 0, RED,    8,  2, 1, 0, REQUEST);
        add(0, 1, RED,    8,  3, 1, 0, REQUEST);
        add(0, 0, RED,    8,  3, 1, 0, REQUEST);
        // service
        add(0, 1, RED,    8,  4, 1, 0, REQUEST);
        add(0, 1, GREEN,  4,  4, 1, 0, SERVE);
        add(0, 0, GREEN,  8,  3, 1, 0, SERVE);
        add(0, 1, GREEN,  8,  4, 1, 0, SERVE);
        add(0, 0, GREEN,  8,  3, 1, 0, SERVE);
        add(0, 0, YELLOW, 2,  3, 1, 0, REQUEST);
        // mixed: arrival on green, then yellow
        add(1, 1, GREEN,  8,  1, 1, 0, SERVE);
        add(0, 1, YELLOW, 2,  1, 1, 0, REQUEST);
        add(0, 0, YELLOW, 8,  1, 1, 0, REQUEST);
        add(0, 1, YELLOW, 8,  2, 1, 0, REQUEST);
        add(0, 0, YELLOW, 8,  2, 1, 0, REQUEST);
        add(0, 0, 2'd3,   4,  2, 1, 0, REQUEST);

        tick(2);
        clr_n = 1'b1;
        tick(1);
        outs("reset", 0, 0, 0);
        check("reset.state", int'(dut.state), int'(IDLE));

        // exact arrival latency: request on the 7th edge
        loop_raw = 1'b1;
        tick(6);
        outs("lat6", 0, 0, 0);
        tick(1);
        outs("lat7", 1, 1, 0);
        tick(1);
        loop_raw = 1'b0;
        tick(10);
        outs("latfall", 1, 1, 0);
        check("latfall.state", int'(dut.state), int'(REQUEST));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (tbl[i].rst) sync_reset();
            loop_raw = tbl[i].loop;
            bif.csig = tbl[i].csig;
            tick(tbl[i].n);
            outs(tag, tbl[i].cnt, tbl[i].car, tbl[i].ovf);
            check({tag, ".state"}, int'(dut.state), tbl[i].st);
        end

        // serve down to zero: request drops on the same edge
        sync_reset();
        loop_raw = 1'b1;
        tick(8);
        bif.csig = GREEN;
        tick(2);
        loop_raw = 1'b0;
        tick(6);
        outs("zero6", 1, 1, 0);
        tick(1);
        outs("zero7", 0, 0, 0);
        tick(3);
        check("zero.hold_serve", int'(dut.state), int'(SERVE));
        bif.csig = RED;
        tick(1);
        check("zero.idle", int'(dut.state), int'(IDLE));

        // departure in the very cycle csig turns green
        sync_reset();
        loop_raw = 1'b1;
        tick(8);
        loop_raw = 1'b0;
        tick(6);
        outs("samecyc.pre", 1, 1, 0);
        bif.csig = GREEN;
        tick(1);
        outs("samecyc", 0, 0, 0);
        check("samecyc.state", int'(dut.state), int'(SERVE));

        // saturation
        sync_reset();
        for (int i = 0; i < 16; i++) begin
            loop_raw = 1'b1;
            tick(8);
            loop_raw = 1'b0;
            tick(8);
            if (i == 14) outs("sat15", 15, 1, 0);
        end
        outs("sat16", 15, 1, 1);
        bif.csig = GREEN;
        loop_raw = 1'b1;
        tick(8);
        outs("satserve.in", 15, 1, 1);
        loop_raw = 1'b0;
        tick(8);
        outs("satserve.out", 14, 1, 1);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        outs("async", 0, 0, 0);
        check("async.state", int'(dut.state), int'(IDLE));
        bif.csig = RED;
        tick(2);
        clr_n = 1'b1;
        tick(2);
        outs("post", 0, 0, 0);
        check("post.state", int'(dut.state), int'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
